// File: rtl/carwash_pkg.sv
// Shared types and helpers for the carwash controller.
// The optional refund feature is selected in carwash_ctrl by CARWASH_REFUND_EN.
package carwash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_SPRAY_PH,
        ST_SOAP_PH,
        ST_RINSE_PH
    } carwash_state_t;

    typedef enum logic {
        BASIC,
        DELUXE
    } wash_mode_t;

    // The timer holds (phase length - 1), so $clog2 of the longest phase is enough.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/carwash_timer.sv
// Loadable phase down-counter; o_done is high while the count is zero.
module carwash_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/carwash_ctrl.sv
// Token-operated carwash sequencer (basic rinse or deluxe spray/soap/rinse).
// Define CARWASH_REFUND_EN to enable CANCEL-driven credit refunds.
module carwash_ctrl
    import carwash_pkg::*;
#(
    parameter int CREDIT_W      = 4,
    parameter int BASIC_TOKENS  = 1,
    parameter int DELUXE_TOKENS = 2,
    parameter int SPRAY_CYC     = 16,
    parameter int SOAP_CYC      = 16,
    parameter int RINSE_CYC     = 16
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                TOKEN,
    input  logic                START,
    input  logic                CANCEL,
    output logic                SPRAY,
    output logic                SOAP,
    output logic                BUSY,
    output logic                DONE,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic                REFUND,
    output logic [CREDIT_W-1:0] REFUND_AMT
);

    localparam int unsigned TW = timer_width(SPRAY_CYC, SOAP_CYC, RINSE_CYC);

    localparam logic [CREDIT_W-1:0] P_BASIC  = CREDIT_W'(BASIC_TOKENS);
    localparam logic [CREDIT_W-1:0] P_DELUXE = CREDIT_W'(DELUXE_TOKENS);
    localparam logic [TW-1:0]       SPRAY_LD = TW'(SPRAY_CYC - 1);
    localparam logic [TW-1:0]       SOAP_LD  = TW'(SOAP_CYC - 1);
    localparam logic [TW-1:0]       RINSE_LD = TW'(RINSE_CYC - 1);

    carwash_state_t      r_state;
    carwash_state_t      w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] w_credit_inc;
    logic [CREDIT_W-1:0] w_tok_ext;
    logic [CREDIT_W-1:0] w_price;
    wash_mode_t          w_mode;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_load;
    logic [TW-1:0]       w_load_val;
    logic                w_tmr_done;

`ifdef CARWASH_REFUND_EN
    logic                r_refund;
    logic                w_refund_nxt;
    logic [CREDIT_W-1:0] r_refund_amt;
    logic [CREDIT_W-1:0] w_refund_amt_nxt;
`endif

    carwash_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_tmr_done)
    );

    assign w_tok_ext    = {{(CREDIT_W-1){1'b0}}, TOKEN};
    assign w_credit_inc = (TOKEN && (r_credit != '1)) ? (r_credit + 1'b1) : r_credit;
    assign w_mode       = (r_credit >= P_DELUXE) ? DELUXE : BASIC;
    assign w_price      = (w_mode == DELUXE) ? P_DELUXE : P_BASIC;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_IDLE;
            r_credit <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = w_credit_inc;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
`ifdef CARWASH_REFUND_EN
        w_refund_nxt     = 1'b0;
        w_refund_amt_nxt = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_credit != '0) w_state_nxt = ST_CREDIT;
            end
            ST_CREDIT: begin
                // Price is judged on pre-token credit; the token still lands this cycle.
                if (START && (r_credit >= P_BASIC)) begin
                    w_credit_nxt = r_credit - w_price + w_tok_ext;
                    w_load       = 1'b1;
                    if (w_mode == DELUXE) begin
                        w_state_nxt = ST_SPRAY_PH;
                        w_load_val  = SPRAY_LD;
                    end else begin
                        w_state_nxt = ST_RINSE_PH;
                        w_load_val  = RINSE_LD;
                    end
                end
`ifdef CARWASH_REFUND_EN
                else if (CANCEL) begin
                    w_refund_nxt     = 1'b1;
                    w_refund_amt_nxt = w_credit_inc;
                    w_credit_nxt     = '0;
                    w_state_nxt      = ST_IDLE;
                end
`endif
            end
            ST_SPRAY_PH: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_SOAP_PH;
                    w_load      = 1'b1;
                    w_load_val  = SOAP_LD;
                end
            end
            ST_SOAP_PH: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_RINSE_PH;
                    w_load      = 1'b1;
                    w_load_val  = RINSE_LD;
                end
            end
            ST_RINSE_PH: begin
                if (w_tmr_done) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = (r_credit != '0) ? ST_CREDIT : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef CARWASH_REFUND_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_refund     <= 1'b0;
            r_refund_amt <= '0;
        end else begin
            r_refund     <= w_refund_nxt;
            r_refund_amt <= w_refund_amt_nxt;
        end
    end

    assign REFUND     = r_refund;
    assign REFUND_AMT = r_refund_amt;
`else
    logic w_unused_cancel;
    assign w_unused_cancel = CANCEL;
    assign REFUND          = 1'b0;
    assign REFUND_AMT      = '0;
`endif

    assign SPRAY  = (r_state == ST_SPRAY_PH) || (r_state == ST_RINSE_PH);
    assign SOAP   = (r_state == ST_SOAP_PH);
    assign BUSY   = (r_state == ST_SPRAY_PH) || (r_state == ST_SOAP_PH) ||
                    (r_state == ST_RINSE_PH);
    assign DONE   = r_done;
    assign CREDIT = r_credit;

endmodule

// File: tb/tb_carwash_ctrl.sv
// Bench for carwash_ctrl: directed scenarios plus randomized traffic vs a schedule-based model.
// Honours CARWASH_REFUND_EN the same way the design does.
module tb_carwash_ctrl;

    localparam int CW   = 4;
    localparam int BT   = 1;
    localparam int DT   = 2;
    localparam int SC   = 4;
    localparam int OC   = 3;
    localparam int RC   = 5;
    localparam int MAXC = 15;
`ifdef CARWASH_REFUND_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr_n, TOKEN, START, CANCEL;
    logic          SPRAY, SOAP, BUSY, DONE, REFUND;
    logic [CW-1:0] CREDIT, REFUND_AMT;

    int n_pass  = 0;
    int n_total = 0;

    // Model: credit, whether the machine accepts START, and a per-cycle queue of {spray,soap}.
    int       m_credit;
    bit       m_ready;
    bit [1:0] m_sched[$];
    bit       m_done, m_ref;
    int       m_amt;

    always #5 clk = ~clk;

    carwash_ctrl #(
        .CREDIT_W      (CW),
        .BASIC_TOKENS  (BT),
        .DELUXE_TOKENS (DT),
        .SPRAY_CYC     (SC),
        .SOAP_CYC      (OC),
        .RINSE_CYC     (RC)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .TOKEN      (TOKEN),
        .START      (START),
        .CANCEL     (CANCEL),
        .SPRAY      (SPRAY),
        .SOAP       (SOAP),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CREDIT     (CREDIT),
        .REFUND     (REFUND),
        .REFUND_AMT (REFUND_AMT)
    );

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [4:0] m_out();
        if (m_sched.size() != 0)
            return {m_sched[0][1], m_sched[0][0], 1'b1, m_done, m_ref};
        return {3'b000, m_done, m_ref};
    endfunction

    task automatic model_clear();
        m_credit = 0; m_ready = 1'b0; m_sched.delete();
        m_done = 1'b0; m_ref = 1'b0; m_amt = 0;
    endtask

    // Drive one cycle of inputs, advance the model, land 1 time unit past the edge.
    task automatic step(input bit tok, input bit st, input bit cn);
        int pre, inc, price;
        TOKEN = tok; START = st; CANCEL = cn;
        pre = m_credit; inc = sat(pre + int'(tok));
        m_done = 1'b0; m_ref = 1'b0; m_amt = 0;
        if (m_sched.size() != 0) begin
            m_sched.delete(0);
            if (m_sched.size() == 0) begin
                m_done  = 1'b1;
                m_ready = (pre != 0);
            end
            m_credit = inc;
        end else if (!m_ready) begin
            m_ready  = (pre != 0);
            m_credit = inc;
        end else if (st && pre >= BT) begin
            price = (pre >= DT) ? DT : BT;
            if (price == DT) begin
                repeat (SC) m_sched.push_back(2'b10);
                repeat (OC) m_sched.push_back(2'b01);
            end
            repeat (RC) m_sched.push_back(2'b10);
            m_ready  = 1'b0;
            m_credit = pre - price + int'(tok);
        end else if (cn && REF_EN) begin
            m_ref = 1'b1; m_amt = inc; m_credit = 0; m_ready = 1'b0;
        end else begin
            m_credit = inc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0; TOKEN = 1'b0; START = 1'b0; CANCEL = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; TOKEN = 1'b1; START = 1'b0; CANCEL = 1'b0;
        #1;
        n_total++;
        if ({SPRAY, SOAP, BUSY, DONE, REFUND} !== 5'b0)
            $display("FAIL reset_outs: got %b expected 00000", {SPRAY, SOAP, BUSY, DONE, REFUND});
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (CREDIT !== 4'd0 || REFUND_AMT !== 4'd0)
            $display("FAIL reset_credit: got %0d/%0d expected 0/0", CREDIT, REFUND_AMT);
        else n_pass++;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        n_total++;
        if (CREDIT !== 4'd1) $display("FAIL first_token: got %0d expected 1", CREDIT);
        else n_pass++;
    endtask

    task automatic test_deluxe();
        logic [3:0] exp;
        int ndone = 0;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if (CREDIT !== 4'd0) $display("FAIL deluxe_credit: got %0d expected 0", CREDIT);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            if (i < SC)                exp = 4'b1010;
            else if (i < SC + OC)      exp = 4'b0110;
            else if (i < SC + OC + RC) exp = 4'b1010;
            else if (i == SC + OC + RC) exp = 4'b0001;
            else                       exp = 4'b0000;
            ndone += int'(DONE);
            n_total++;
            if ({SPRAY, SOAP, BUSY, DONE} !== exp)
                $display("FAIL deluxe_seq[%0d]: got %b expected %b", i, {SPRAY, SOAP, BUSY, DONE}, exp);
            else n_pass++;
            step(1'b0, 1'b0, 1'b0);
        end
        n_total++;
        if (ndone != 1) $display("FAIL deluxe_done_count: got %0d expected 1", ndone);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if (BUSY !== 1'b0 || CREDIT !== 4'd0)
            $display("FAIL deluxe_idle: got busy=%b credit=%0d expected busy=0 credit=0", BUSY, CREDIT);
        else n_pass++;
    endtask

    task automatic test_basic();
        int nspray = 0, nsoap = 0, ndone = 0;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if (BUSY !== 1'b0) $display("FAIL basic_idle_start: got busy=%b expected 0", BUSY);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if (CREDIT !== 4'd0 || BUSY !== 1'b1)
            $display("FAIL basic_start: got credit=%0d busy=%b expected 0/1", CREDIT, BUSY);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            nspray += int'(SPRAY); nsoap += int'(SOAP); ndone += int'(DONE);
            step(1'b0, 1'b0, 1'b0);
        end
        n_total++;
        if (nspray != RC || nsoap != 0 || ndone != 1)
            $display("FAIL basic_counts: got spray=%0d soap=%0d done=%0d expected %0d/0/1",
                     nspray, nsoap, ndone, RC);
        else n_pass++;
    endtask

    task automatic test_leftover();
        int guard = 0;
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if (CREDIT !== 4'd1 || SPRAY !== 1'b1)
            $display("FAIL leftover_start: got credit=%0d spray=%b expected 1/1", CREDIT, SPRAY);
        else n_pass++;
        while (DONE !== 1'b1 && guard < 40) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        n_total++;
        if (DONE !== 1'b1) $display("FAIL leftover_done_timeout: got done=%b expected 1", DONE);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0);
        n_total++;
        if ({SPRAY, SOAP, BUSY} !== 3'b101 || CREDIT !== 4'd0)
            $display("FAIL leftover_restart: got %b credit=%0d expected 101 credit=0",
                     {SPRAY, SOAP, BUSY}, CREDIT);
        else n_pass++;
        repeat (RC + 2) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (16) step(1'b1, 1'b0, 1'b0);
        n_total++;
        if (CREDIT !== 4'd15) $display("FAIL saturate: got %0d expected 15", CREDIT);
        else n_pass++;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({SPRAY, SOAP, BUSY} !== 3'b101 || CREDIT !== 4'd1)
            $display("FAIL token_with_start: got %b credit=%0d expected 101 credit=1",
                     {SPRAY, SOAP, BUSY}, CREDIT);
        else n_pass++;
        repeat (RC + 2) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_soap();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (SC + 1) step(1'b1, 1'b0, 1'b0);
        n_total++;
        if (SOAP !== 1'b1) $display("FAIL pre_reset_soap: got %b expected 1", SOAP);
        else n_pass++;
        #2;
        clr_n = 1'b0;
        #1;
        n_total++;
        if ({SPRAY, SOAP, BUSY, DONE, REFUND} !== 5'b0 || CREDIT !== 4'd0)
            $display("FAIL async_reset: got %b credit=%0d expected 00000 credit=0",
                     {SPRAY, SOAP, BUSY, DONE, REFUND}, CREDIT);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (DONE !== 1'b0 || BUSY !== 1'b0)
            $display("FAIL reset_no_done: got done=%b busy=%b expected 0/0", DONE, BUSY);
        else n_pass++;
        model_clear();
        clr_n = 1'b1;
    endtask

    task automatic test_cancel();
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_total++;
        if (REF_EN) begin
            if (REFUND !== 1'b1 || REFUND_AMT !== 4'd3 || CREDIT !== 4'd0)
                $display("FAIL refund: got ref=%b amt=%0d credit=%0d expected 1/3/0",
                         REFUND, REFUND_AMT, CREDIT);
            else n_pass++;
        end else begin
            if (REFUND !== 1'b0 || REFUND_AMT !== 4'd0 || CREDIT !== 4'd3)
                $display("FAIL cancel_ignored: got ref=%b amt=%0d credit=%0d expected 0/0/3",
                         REFUND, REFUND_AMT, CREDIT);
            else n_pass++;
        end
        step(1'b0, 1'b0, 1'b0);
        n_total++;
        if (REFUND !== 1'b0) $display("FAIL refund_pulse: got %b expected 0", REFUND);
        else n_pass++;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_total++;
        if (REFUND !== 1'b0 || BUSY !== 1'b1 || CREDIT !== 4'd1)
            $display("FAIL cancel_busy: got ref=%b busy=%b credit=%0d expected 0/1/1",
                     REFUND, BUSY, CREDIT);
        else n_pass++;
        repeat (SC + OC + RC + 2) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        bit tok, st, cn;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 499) do_reset();
            tok = ($urandom_range(0, 5) == 0);
            st  = ($urandom_range(0, 7) == 0);
            cn  = ($urandom_range(0, 11) == 0);
            step(tok, st, cn);
            n_total++;
            if ({SPRAY, SOAP, BUSY, DONE, REFUND} !== m_out() ||
                CREDIT !== m_credit[CW-1:0] || REFUND_AMT !== m_amt[CW-1:0])
                $display("FAIL random[%0d]: got %b c=%0d a=%0d expected %b c=%0d a=%0d", i,
                         {SPRAY, SOAP, BUSY, DONE, REFUND}, CREDIT, REFUND_AMT,
                         m_out(), m_credit, m_amt);
            else n_pass++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_deluxe();
        test_basic();
        test_leftover();
        test_saturate();
        test_reset_mid_soap();
        test_cancel();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
